dispatch_queue: RTL and testbench
=================================

# dispatch_queue

In-order, multi-lane buffer between the decode/rename stage and ROB/reservation-station dispatch. Accepts up to `MACHINE_WIDTH` renamed packets per cycle and presents up to `MACHINE_WIDTH` oldest packets per cycle to dispatch. While packets wait, it snoops writeback broadcasts and sets their operand-ready bits. It is emptied on architectural-state recovery.

## Interface
- `DEPTH`, default 8: entry count; power of two, ≥ 2×`MACHINE_WIDTH`.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rename_pkt` input `RENAME_PACKET [0:MACHINE_WIDTH-1]`: packets from rename; a lane is live when its `packet_valid` is set.
- `rename_pkt_ready` input-side handshake, output `[MACHINE_WIDTH-1:0]`: lane i may enqueue.
- `dispatch_pkt` output `RENAME_PACKET [0:MACHINE_WIDTH-1]`: lane j is the j-th oldest entry.
- `dispatch_pkt_ready` input `[MACHINE_WIDTH-1:0]`: consumer accepts lane j.
- `writeback_dest_prn` input `PRF_WIDTH [0:ISSUE_WIDTH-1]`: completing destination PRNs.
- `writeback_valid` input `[ISSUE_WIDTH-1:0]`: qualifies each writeback lane.
- `recov_arch_st` input 1: flush.

## Operation
- State: entry array, `head` and `tail` pointers (`$clog2(DEPTH)` bits, wrap modulo `DEPTH`), and `count` (`$clog2(DEPTH+1)` bits).
- **Enqueue ready:** `rename_pkt_ready[i] = (DEPTH - count > i) & ~recov_arch_st`.
  - Uses start-of-cycle `count` only; same-cycle dequeues give no credit.
- **Enqueue:** lane i is taken when `packet_valid & rename_pkt_ready[i]`.
  - Taken lanes are compacted in lane order: a lane goes to `tail + (number of taken lanes below i)`.
  - Invalid lanes consume no slot.
- **Output lanes:** `dispatch_pkt[j]` = entry `head+j`; `packet_valid = (count > j) & ~recov_arch_st`.
- **Dequeue:** the dequeue amount is the length of the leading run of j with `packet_valid & dispatch_pkt_ready[j]`.
  - A not-ready lane blocks all later lanes.
  - `head` advances by the dequeue amount.
- **Update:** `count_next = count + enq - deq`. Simultaneous enqueue and dequeue are legal at any occupancy.
- **Wakeup (stored entries):** each cycle, for every valid entry, set `op1_ready` when `use_op1_prn` is set and `op1_prn` equals any valid `writeback_dest_prn`. `op2` is handled the same way.
- **Wakeup (enqueue):** the same match is ORed into the incoming `op1_ready`/`op2_ready` bits at write time, so a same-cycle writeback is never lost.
- Ready bits never clear while an entry is resident.
- **Flush:** `recov_arch_st` high zeroes `head`, `tail` and `count` at the next edge. Enqueues in that cycle are dropped and outputs are invalid during it.
  - Flush has priority over enqueue, dequeue and wakeup.
- **Reset:** `head`, `tail` and `count` go to 0 and all entry contents to 0. Resulting outputs: `dispatch_pkt[*].packet_valid = 0`, `rename_pkt_ready` all 1.
  - Reset may assert mid-operation; buffered packets are discarded.

## Timing
- Enqueue-to-output latency is 1 cycle: a packet accepted at edge N appears on `dispatch_pkt` after N.
- All outputs are combinational from registered state, plus `recov_arch_st`, plus writeback when bypass is enabled. There is no input-to-output combinational path from `rename_pkt`.
- Sustained throughput is `MACHINE_WIDTH`/cycle when `DEPTH` ≥ 2×`MACHINE_WIDTH` and the consumer accepts all lanes.
- Full: `count == DEPTH` gives `rename_pkt_ready = 0`. Empty: all `dispatch_pkt` lanes invalid.

## Configuration
- `DISPATCH_WB_BYPASS_EN` defined: the `op1_ready`/`op2_ready` output bits are additionally ORed with the current-cycle writeback match, so a dispatch in the writeback cycle sees the operand ready.
- Not defined: output ready bits are registered values only; a writeback becomes visible one cycle later.

## Structure
- `RENAME_PACKET`, `MACHINE_WIDTH`, `ISSUE_WIDTH` and `PRF_WIDTH` come from the shared definitions.
- Add `DISPATCH_Q_DEPTH` (default 8) there as the instantiation value.
- One sub-module, `dq_wakeup_match`: takes one PRN plus a `use` bit and the writeback vectors, and returns the match. It is instantiated for each entry operand and for each incoming lane operand.

## Test plan
- Reset, then enqueue 2 valid lanes with PRNs 5 and 6 → next cycle `dispatch_pkt[0..1]` valid in order, `count` = 2, `rename_pkt_ready` reflects `DEPTH` − 2 free.
- Lane 0 invalid, lane 1 valid → packet lands at `head`; `dispatch_pkt[0]` shows the lane-1 packet.
- Fill to `DEPTH` with `dispatch_pkt_ready` = 0 → `rename_pkt_ready` = 0. Then raise `dispatch_pkt_ready[0]` only → exactly 1 dequeue, and 1 slot is offered the following cycle. Continue until pointers wrap past `DEPTH`-1 with order preserved.
- `dispatch_pkt_ready` = `2'b10` → no dequeue (lane 0 blocks).
- Entry waiting on `op1_prn` = 12; `writeback_valid[0]` = 1 with PRN 12:
  - with `DISPATCH_WB_BYPASS_EN`: `op1_ready` is 1 in the same cycle;
  - without it: `op1_ready` is 1 the next cycle.
  - Repeat with the writeback in the enqueue cycle → the stored entry has `op1_ready` = 1.
- Assert `recov_arch_st` with 5 entries plus a concurrent enqueue → outputs invalid that cycle; next cycle `count` = 0, no dispatch valid, `rename_pkt_ready` all 1.

Source files
------------

// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the dispatch queue: machine widths, PRF width and the renamed packet format.
// Also holds DISPATCH_Q_DEPTH, the depth used when dispatch_queue is instantiated.
package dispatch_queue_pkg;

    localparam int MACHINE_WIDTH    = 2;
    localparam int ISSUE_WIDTH      = 2;
    localparam int PRF_WIDTH        = 6;
    localparam int DISPATCH_Q_DEPTH = 8;

    typedef struct packed {
        logic                 packet_valid;
        logic [7:0]           tag;
        logic [PRF_WIDTH-1:0] dest_prn;
        logic                 use_op1_prn;
        logic [PRF_WIDTH-1:0] op1_prn;
        logic                 op1_ready;
        logic                 use_op2_prn;
        logic [PRF_WIDTH-1:0] op2_prn;
        logic                 op2_ready;
    } RENAME_PACKET;

endpackage

// File: rtl/dispatch_queue_wakeup.sv
// dq_wakeup_match: reports whether one source PRN (gated by its use bit)
// matches any valid writeback lane this cycle.
module dq_wakeup_match
    import dispatch_queue_pkg::*;
(
    input  logic [PRF_WIDTH-1:0]   prn_i,
    input  logic                   use_i,
    input  logic [PRF_WIDTH-1:0]   wb_prn_i [0:ISSUE_WIDTH-1],
    input  logic [ISSUE_WIDTH-1:0] wb_valid_i,
    output logic                   match_o
);

    // OR-reduce the per-lane PRN compares
    always_comb begin
        match_o = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            match_o = match_o | (use_i & wb_valid_i[k] & (wb_prn_i[k] == prn_i));
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order multi-lane dispatch queue with writeback wakeup and flush.
// Optional macro DISPATCH_WB_BYPASS_EN: OR the current-cycle writeback match into the output ready bits.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = DISPATCH_Q_DEPTH
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  RENAME_PACKET             rename_pkt [0:MACHINE_WIDTH-1],
    output logic [MACHINE_WIDTH-1:0] rename_pkt_ready,
    output RENAME_PACKET             dispatch_pkt [0:MACHINE_WIDTH-1],
    input  logic [MACHINE_WIDTH-1:0] dispatch_pkt_ready,
    input  logic [PRF_WIDTH-1:0]     writeback_dest_prn [0:ISSUE_WIDTH-1],
    input  logic [ISSUE_WIDTH-1:0]   writeback_valid,
    input  logic                     recov_arch_st
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    RENAME_PACKET     entries_q [0:DEPTH-1];
    RENAME_PACKET     entries_d [0:DEPTH-1];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0]         free_s;
    logic [CNT_W-1:0]         enq_cnt_s;
    logic [CNT_W-1:0]         deq_cnt_s;
    logic                     run_s;
    logic [MACHINE_WIDTH-1:0] take_s;
    logic [PTR_W-1:0]         wr_idx_s [0:MACHINE_WIDTH-1];
    logic [PTR_W-1:0]         rd_idx_s [0:MACHINE_WIDTH-1];
    logic [DEPTH-1:0]         ent_m1_s, ent_m2_s;
    logic [MACHINE_WIDTH-1:0] lane_m1_s, lane_m2_s;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent_wake
        dq_wakeup_match u_m1 (
            .prn_i      (entries_q[e].op1_prn),
            .use_i      (entries_q[e].use_op1_prn),
            .wb_prn_i   (writeback_dest_prn),
            .wb_valid_i (writeback_valid),
            .match_o    (ent_m1_s[e])
        );
        dq_wakeup_match u_m2 (
            .prn_i      (entries_q[e].op2_prn),
            .use_i      (entries_q[e].use_op2_prn),
            .wb_prn_i   (writeback_dest_prn),
            .wb_valid_i (writeback_valid),
            .match_o    (ent_m2_s[e])
        );
    end

    for (genvar i = 0; i < MACHINE_WIDTH; i++) begin : g_lane_wake
        dq_wakeup_match u_m1 (
            .prn_i      (rename_pkt[i].op1_prn),
            .use_i      (rename_pkt[i].use_op1_prn),
            .wb_prn_i   (writeback_dest_prn),
            .wb_valid_i (writeback_valid),
            .match_o    (lane_m1_s[i])
        );
        dq_wakeup_match u_m2 (
            .prn_i      (rename_pkt[i].op2_prn),
            .use_i      (rename_pkt[i].use_op2_prn),
            .wb_prn_i   (writeback_dest_prn),
            .wb_valid_i (writeback_valid),
            .match_o    (lane_m2_s[i])
        );
    end

    // Enqueue side: ready from start-of-cycle count, taken lanes compacted onto tail
    always_comb begin
        free_s    = CNT_W'(DEPTH) - count_q;
        enq_cnt_s = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            rename_pkt_ready[i] = (free_s > CNT_W'(i)) & ~recov_arch_st;
            take_s[i]           = rename_pkt[i].packet_valid & rename_pkt_ready[i];
            wr_idx_s[i]         = tail_q + PTR_W'(enq_cnt_s);
            enq_cnt_s           = enq_cnt_s + CNT_W'(take_s[i]);
        end
    end

    // Dispatch side: present oldest entries and measure the leading accepted run
    always_comb begin
        deq_cnt_s = '0;
        run_s     = 1'b1;
        for (int j = 0; j < MACHINE_WIDTH; j++) begin
            rd_idx_s[j]                  = head_q + PTR_W'(j);
            dispatch_pkt[j]              = entries_q[rd_idx_s[j]];
            dispatch_pkt[j].packet_valid = (count_q > CNT_W'(j)) & ~recov_arch_st;
`ifdef DISPATCH_WB_BYPASS_EN
            dispatch_pkt[j].op1_ready = entries_q[rd_idx_s[j]].op1_ready | ent_m1_s[rd_idx_s[j]];
            dispatch_pkt[j].op2_ready = entries_q[rd_idx_s[j]].op2_ready | ent_m2_s[rd_idx_s[j]];
`else
            dispatch_pkt[j].op1_ready = entries_q[rd_idx_s[j]].op1_ready;
            dispatch_pkt[j].op2_ready = entries_q[rd_idx_s[j]].op2_ready;
`endif
            run_s     = run_s & dispatch_pkt[j].packet_valid & dispatch_pkt_ready[j];
            deq_cnt_s = deq_cnt_s + CNT_W'(run_s);
        end
    end

    // Next state: flush wins; otherwise wake stored entries, then write new lanes
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (recov_arch_st) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                entries_d[e].op1_ready = entries_q[e].op1_ready | ent_m1_s[e];
                entries_d[e].op2_ready = entries_q[e].op2_ready | ent_m2_s[e];
            end
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                entries_d[wr_idx_s[i]] = take_s[i] ? rename_pkt[i] : entries_d[wr_idx_s[i]];
                entries_d[wr_idx_s[i]].op1_ready = take_s[i]
                    ? (rename_pkt[i].op1_ready | lane_m1_s[i]) : entries_d[wr_idx_s[i]].op1_ready;
                entries_d[wr_idx_s[i]].op2_ready = take_s[i]
                    ? (rename_pkt[i].op2_ready | lane_m2_s[i]) : entries_d[wr_idx_s[i]].op2_ready;
            end
            head_d  = head_q + PTR_W'(deq_cnt_s);
            tail_d  = tail_q + PTR_W'(enq_cnt_s);
            count_d = count_q + enq_cnt_s - deq_cnt_s;
        end
    end

    // State registers with asynchronous clear of pointers and entry contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                entries_q[e] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: table-driven enqueue/dequeue vectors plus
// hand sequences for full/wrap, wakeup (with or without DISPATCH_WB_BYPASS_EN), flush and reset.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    logic                     clk;
    logic                     rst_n;
    RENAME_PACKET             rename_pkt [0:MACHINE_WIDTH-1];
    logic [MACHINE_WIDTH-1:0] rename_pkt_ready;
    RENAME_PACKET             dispatch_pkt [0:MACHINE_WIDTH-1];
    logic [MACHINE_WIDTH-1:0] dispatch_pkt_ready;
    logic [PRF_WIDTH-1:0]     writeback_dest_prn [0:ISSUE_WIDTH-1];
    logic [ISSUE_WIDTH-1:0]   writeback_valid;
    logic                     recov_arch_st;

    int checks = 0;
    int errors = 0;

`ifdef DISPATCH_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    dispatch_queue #(.DEPTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rename_pkt         (rename_pkt),
        .rename_pkt_ready   (rename_pkt_ready),
        .dispatch_pkt       (dispatch_pkt),
        .dispatch_pkt_ready (dispatch_pkt_ready),
        .writeback_dest_prn (writeback_dest_prn),
        .writeback_valid    (writeback_valid),
        .recov_arch_st      (recov_arch_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] v;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [1:0] drdy;
        logic [1:0] exp_rdy;
        logic [1:0] exp_dv;
        logic [7:0] exp_t0;
        logic [7:0] exp_t1;
    } vec_t;

    vec_t vecs [0:9];

    function automatic RENAME_PACKET mk(input logic v, input logic [7:0] t,
                                        input logic u1, input logic [5:0] p1,
                                        input logic u2, input logic [5:0] p2);
        RENAME_PACKET p;
        p              = '0;
        p.packet_valid = v;
        p.tag          = t;
        p.dest_prn     = t[5:0];
        p.use_op1_prn  = u1;
        p.op1_prn      = p1;
        p.use_op2_prn  = u2;
        p.op2_prn      = p2;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] t0, input logic [7:0] t1,
                         input logic [1:0] dr);
        rename_pkt[0]      = mk(v[0], t0, 1'b0, 6'd0, 1'b0, 6'd0);
        rename_pkt[1]      = mk(v[1], t1, 1'b0, 6'd0, 1'b0, 6'd0);
        dispatch_pkt_ready = dr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [1:0] dv();
        return {dispatch_pkt[1].packet_valid, dispatch_pkt[0].packet_valid};
    endfunction

    initial begin
        //            v      t0     t1     drdy   rdy    dv     et0    et1
        vecs[0] = '{2'b00, 8'd0,  8'd0,  2'b00, 2'b11, 2'b00, 8'd0,  8'd0 };
        vecs[1] = '{2'b11, 8'd5,  8'd6,  2'b00, 2'b11, 2'b00, 8'd0,  8'd0 };
        vecs[2] = '{2'b10, 8'd99, 8'd7,  2'b00, 2'b11, 2'b11, 8'd5,  8'd6 };
        vecs[3] = '{2'b00, 8'd0,  8'd0,  2'b10, 2'b11, 2'b11, 8'd5,  8'd6 };
        vecs[4] = '{2'b00, 8'd0,  8'd0,  2'b01, 2'b11, 2'b11, 8'd5,  8'd6 };
        vecs[5] = '{2'b00, 8'd0,  8'd0,  2'b11, 2'b11, 2'b11, 8'd6,  8'd7 };
        vecs[6] = '{2'b10, 8'd98, 8'd8,  2'b11, 2'b11, 2'b00, 8'd0,  8'd0 };
        vecs[7] = '{2'b11, 8'd9,  8'd10, 2'b11, 2'b11, 2'b01, 8'd8,  8'd0 };
        vecs[8] = '{2'b00, 8'd0,  8'd0,  2'b00, 2'b11, 2'b11, 8'd9,  8'd10};
        vecs[9] = '{2'b00, 8'd0,  8'd0,  2'b11, 2'b11, 2'b11, 8'd9,  8'd10};

        rst_n                 = 1'b0;
        recov_arch_st         = 1'b0;
        writeback_valid       = 2'b00;
        writeback_dest_prn[0] = 6'd0;
        writeback_dest_prn[1] = 6'd0;
        drive(2'b00, 8'd0, 8'd0, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            drive(vecs[k].v, vecs[k].t0, vecs[k].t1, vecs[k].drdy);
            #1;
            chk($sformatf("vec%0d_rdy", k), 32'(rename_pkt_ready), 32'(vecs[k].exp_rdy));
            chk($sformatf("vec%0d_dv", k), 32'(dv()), 32'(vecs[k].exp_dv));
            if (vecs[k].exp_dv[0]) chk($sformatf("vec%0d_tag0", k), 32'(dispatch_pkt[0].tag), 32'(vecs[k].exp_t0));
            if (vecs[k].exp_dv[1]) chk($sformatf("vec%0d_tag1", k), 32'(dispatch_pkt[1].tag), 32'(vecs[k].exp_t1));
            tick();
        end

        // fill to full with consumer stalled
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 8'(20 + 2 * k), 8'(21 + 2 * k), 2'b00);
            #1;
            chk($sformatf("fill%0d_rdy", k), 32'(rename_pkt_ready), 32'(2'b11));
            tick();
        end
        drive(2'b11, 8'd28, 8'd29, 2'b01);
        #1;
        chk("full_rdy", 32'(rename_pkt_ready), 32'(2'b00));
        chk("full_dv", 32'(dv()), 32'(2'b11));
        chk("full_tag0", 32'(dispatch_pkt[0].tag), 32'd20);
        tick();
        drive(2'b11, 8'd28, 8'd29, 2'b00);
        #1;
        chk("one_slot_rdy", 32'(rename_pkt_ready), 32'(2'b01));
        chk("after_deq1_tag0", 32'(dispatch_pkt[0].tag), 32'd21);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 8'd0, 8'd0, 2'b11);
            #1;
            chk($sformatf("wrap%0d_dv", k), 32'(dv()), 32'(2'b11));
            chk($sformatf("wrap%0d_tag0", k), 32'(dispatch_pkt[0].tag), 32'(21 + 2 * k));
            chk($sformatf("wrap%0d_tag1", k), 32'(dispatch_pkt[1].tag), 32'(22 + 2 * k));
            tick();
        end
        drive(2'b00, 8'd0, 8'd0, 2'b00);
        #1;
        chk("drained_dv", 32'(dv()), 32'(2'b00));

        // wakeup of a stored entry
        rename_pkt[0] = mk(1'b1, 8'd40, 1'b1, 6'd12, 1'b1, 6'd13);
        tick();
        drive(2'b00, 8'd0, 8'd0, 2'b00);
        #1;
        chk("wait_op1", 32'(dispatch_pkt[0].op1_ready), 32'd0);
        writeback_dest_prn[0] = 6'd12;
        writeback_valid       = 2'b01;
        #1;
        chk("wb_same_cycle_op1", 32'(dispatch_pkt[0].op1_ready), 32'(BYP));
        chk("wb_same_cycle_op2", 32'(dispatch_pkt[0].op2_ready), 32'd0);
        tick();
        writeback_valid       = 2'b00;
        writeback_dest_prn[1] = 6'd13;
        #1;
        chk("wb_next_op1", 32'(dispatch_pkt[0].op1_ready), 32'd1);
        chk("wb_next_op2", 32'(dispatch_pkt[0].op2_ready), 32'd0);
        tick();
        chk("wb_invalid_lane_op2", 32'(dispatch_pkt[0].op2_ready), 32'd0);

        // writeback in the enqueue cycle; op1 has no use bit so must stay clear
        rename_pkt[0]         = mk(1'b1, 8'd41, 1'b0, 6'd33, 1'b1, 6'd33);
        writeback_dest_prn[1] = 6'd33;
        writeback_valid       = 2'b10;
        tick();
        writeback_valid = 2'b00;
        drive(2'b00, 8'd0, 8'd0, 2'b00);
        #1;
        chk("enq_wb_tag", 32'(dispatch_pkt[1].tag), 32'd41);
        chk("enq_wb_op2", 32'(dispatch_pkt[1].op2_ready), 32'd1);
        chk("enq_wb_op1_nouse", 32'(dispatch_pkt[1].op1_ready), 32'd0);
        dispatch_pkt_ready = 2'b11;
        tick();

        // flush with five resident entries and a concurrent enqueue
        drive(2'b11, 8'd50, 8'd51, 2'b00);
        tick();
        drive(2'b11, 8'd52, 8'd53, 2'b00);
        tick();
        drive(2'b01, 8'd54, 8'd0, 2'b00);
        tick();
        drive(2'b11, 8'd60, 8'd61, 2'b11);
        recov_arch_st = 1'b1;
        #1;
        chk("flush_dv", 32'(dv()), 32'(2'b00));
        chk("flush_rdy", 32'(rename_pkt_ready), 32'(2'b00));
        tick();
        recov_arch_st = 1'b0;
        drive(2'b01, 8'd70, 8'd0, 2'b00);
        #1;
        chk("post_flush_dv", 32'(dv()), 32'(2'b00));
        chk("post_flush_rdy", 32'(rename_pkt_ready), 32'(2'b11));
        tick();
        drive(2'b11, 8'd71, 8'd72, 2'b00);
        #1;
        chk("post_flush_enq_dv", 32'(dv()), 32'(2'b01));
        chk("post_flush_enq_tag", 32'(dispatch_pkt[0].tag), 32'd70);
        tick();

        // asynchronous reset mid-operation
        drive(2'b00, 8'd0, 8'd0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_dv", 32'(dv()), 32'(2'b00));
        chk("mid_reset_rdy", 32'(rename_pkt_ready), 32'(2'b11));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after_reset_dv", 32'(dv()), 32'(2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
